// File: rtl/sixty_four_bit_pipelined_adder.sv
// sixty_four_bit_pipelined_adder
//
// Four-stage pipelined 64-bit adder with valid/ready handshakes and ADDS
// flags. Each stage adds one 16-bit slice and registers its carry for the
// next stage. The whole pipe advances together or freezes together: a stall
// holds every stage, bubbles included.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands valid this cycle
//   in_ready   block accepts operands this cycle (combinational)
//   a_in       operand A
//   b_in       operand B
//   carry_in   carry into bit 0
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        a_in + b_in + carry_in, mod 2^64
//   carry_out  carry out of bit 63 (C)
//   overflow   signed overflow (V)
//   zero       sum == 0 (Z)
//   negative   sum[63] (N)

module sixty_four_bit_pipelined_adder #(
  parameter int SLICE_W = 16,
  parameter int STAGES  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SLICE_W*STAGES-1:0]   a_in,
  input  logic [SLICE_W*STAGES-1:0]   b_in,
  input  logic                        carry_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SLICE_W*STAGES-1:0]   sum,
  output logic                        carry_out,
  output logic                        overflow,
  output logic                        zero,
  output logic                        negative
);

  localparam int S = SLICE_W;
  localparam int W = SLICE_W * STAGES;

  // Stage 0: slice 0 done, upper operand slices carried forward.
  logic             v0_q, v0_d;
  logic             c0_q, c0_d;
  logic [S-1:0]     s0_q, s0_d;
  logic [W-1:S]     a0_q, a0_d;
  logic [W-1:S]     b0_q, b0_d;

  // Stage 1: slices 0..1 done.
  logic             v1_q, v1_d;
  logic             c1_q, c1_d;
  logic [2*S-1:0]   s1_q, s1_d;
  logic [W-1:2*S]   a1_q, a1_d;
  logic [W-1:2*S]   b1_q, b1_d;

  // Stage 2: slices 0..2 done.
  logic             v2_q, v2_d;
  logic             c2_q, c2_d;
  logic [3*S-1:0]   s2_q, s2_d;
  logic [W-1:3*S]   a2_q, a2_d;
  logic [W-1:3*S]   b2_q, b2_d;

  // Stage 3: output registers.
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;

  logic             adv;
  logic             accept;
  logic [S:0]       add0, add1, add2, add3;
  logic [W-1:0]     full_sum;

  always_comb begin
    adv    = !out_valid_q || out_ready;
    accept = in_valid && adv;

    add0 = {1'b0, a_in[S-1:0]}       + {1'b0, b_in[S-1:0]}       + (S+1)'(carry_in);
    add1 = {1'b0, a0_q[2*S-1:S]}     + {1'b0, b0_q[2*S-1:S]}     + (S+1)'(c0_q);
    add2 = {1'b0, a1_q[3*S-1:2*S]}   + {1'b0, b1_q[3*S-1:2*S]}   + (S+1)'(c1_q);
    add3 = {1'b0, a2_q[W-1:3*S]}     + {1'b0, b2_q[W-1:3*S]}     + (S+1)'(c2_q);
    full_sum = {add3[S-1:0], s2_q};

    v0_d = v0_q; c0_d = c0_q; s0_d = s0_q; a0_d = a0_q; b0_d = b0_q;
    v1_d = v1_q; c1_d = c1_q; s1_d = s1_q; a1_d = a1_q; b1_d = b1_q;
    v2_d = v2_q; c2_d = c2_q; s2_d = s2_q; a2_d = a2_q; b2_d = b2_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    negative_d  = negative_q;

    if (adv) begin
      // Valid bits always shift; data only loads behind a valid entry, so a
      // bubble leaves the downstream data untouched and the outputs stay at
      // their last real result (or zero after reset).
      v0_d        = accept;
      v1_d        = v0_q;
      v2_d        = v1_q;
      out_valid_d = v2_q;

      if (accept) begin
        c0_d = add0[S];
        s0_d = add0[S-1:0];
        a0_d = a_in[W-1:S];
        b0_d = b_in[W-1:S];
      end

      if (v0_q) begin
        c1_d = add1[S];
        s1_d = {add1[S-1:0], s0_q};
        a1_d = a0_q[W-1:2*S];
        b1_d = b0_q[W-1:2*S];
      end

      if (v1_q) begin
        c2_d = add2[S];
        s2_d = {add2[S-1:0], s1_q};
        a2_d = a1_q[W-1:3*S];
        b2_d = b1_q[W-1:3*S];
      end

      if (v2_q) begin
        sum_d       = full_sum;
        carry_out_d = add3[S];
        // Signed overflow: operands agree in sign, result does not.
        overflow_d  = (a2_q[W-1] == b2_q[W-1]) && (full_sum[W-1] != a2_q[W-1]);
        zero_d      = (full_sum == '0);
        negative_d  = full_sum[W-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v0_q <= 1'b0; c0_q <= 1'b0; s0_q <= '0; a0_q <= '0; b0_q <= '0;
      v1_q <= 1'b0; c1_q <= 1'b0; s1_q <= '0; a1_q <= '0; b1_q <= '0;
      v2_q <= 1'b0; c2_q <= 1'b0; s2_q <= '0; a2_q <= '0; b2_q <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else begin
      v0_q <= v0_d; c0_q <= c0_d; s0_q <= s0_d; a0_q <= a0_d; b0_q <= b0_d;
      v1_q <= v1_d; c1_q <= c1_d; s1_q <= s1_d; a1_q <= a1_d; b1_q <= b1_d;
      v2_q <= v2_d; c2_q <= c2_d; s2_q <= s2_d; a2_q <= a2_d; b2_q <= b2_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

endmodule

// File: tb/tb_sixty_four_bit_pipelined_adder.sv
// tb_sixty_four_bit_pipelined_adder
//
// Directed bench for the pipelined adder. Expected results come from a
// 65-bit reference add and sit in a scoreboard queue until the DUT hands
// them over on the output handshake.

module tb_sixty_four_bit_pipelined_adder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic        negative;

  sixty_four_bit_pipelined_adder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  logic [67:0] sbq[$];
  logic        acc;
  logic        obs_valid;
  logic        obs_rdy;
  logic [68:0] obs_all;
  logic        stall_prev = 1'b0;
  logic [67:0] held;
  int          stall_cycles = 0;

  // {sum, C, V, Z, N}
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic ci);
    logic [64:0] t;
    t = {1'b0, a} + {1'b0, b} + {64'd0, ci};
    return {t[63:0], t[64], (a[63] == b[63]) && (t[63] != a[63]),
            t[63:0] == 64'd0, t[63]};
  endfunction

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample 1 ns after the falling edge (inputs already
  // driven), run the scoreboard on both handshakes, then wait for the next
  // falling edge. The rising edge in between commits the transfer.
  task automatic cyc();
    logic [67:0] e;
    #1;
    obs_valid = out_valid;
    obs_rdy   = in_ready;
    obs_all   = {out_valid, sum, carry_out, overflow, zero, negative};
    acc       = 1'b0;
    if (reset) begin
      sbq.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("hold_stable", obs_all, {1'b1, held});
      if (out_valid && !out_ready) begin
        stall_cycles++;
        chk("in_ready_stall", 69'(in_ready), 69'(0));
      end
      if (out_valid && out_ready) begin
        chk("scoreboard_nonempty", 69'(sbq.size() != 0), 69'(1));
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("result", 69'({sum, carry_out, overflow, zero, negative}), 69'(e));
        end
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        sbq.push_back(model(a_in, b_in, carry_in));
      end
      stall_prev = out_valid && !out_ready;
      held       = {sum, carry_out, overflow, zero, negative};
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic ci);
    a_in     = a;
    b_in     = b;
    carry_in = ci;
    in_valid = 1'b1;
    cyc();
    chk("accept", 69'(acc), 69'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && sbq.size() != 0; k++) cyc();
    chk("drained", 69'(sbq.size()), 69'(0));
  endtask

  task automatic run_vec(input logic [63:0] a, input logic [63:0] b, input logic ci);
    send(a, b, ci);
    drain();
  endtask

  task automatic latency_check(input string tag);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk(tag, 69'(obs_valid), 69'(k == 4));
    end
  endtask

  int issued;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    carry_in  = 1'b0;

    @(negedge clk);
    cyc();
    cyc();
    reset = 1'b0;

    cyc();
    chk("reset_outputs", obs_all, 69'(0));
    chk("reset_in_ready", 69'(obs_rdy), 69'(1));

    // Basic add with exact latency.
    send(64'd54, 64'd17, 1'b0);
    latency_check("latency_basic");

    run_vec(64'd54, 64'hFFFF_FFFF_FFFF_FFEF, 1'b0);
    run_vec(64'd10, 64'hFFFF_FFFF_FFFF_FFEF, 1'b0);
    run_vec(64'd54, ~64'd17, 1'b1);
    run_vec(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    run_vec(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    run_vec(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    run_vec(64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    run_vec(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);

    // Back-to-back with a three-cycle output stall.
    issued       = 0;
    stall_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (issued >= 6 && sbq.size() == 0) break;
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (issued < 6);
      a_in      = 64'(issued);
      b_in      = 64'(100 * issued);
      carry_in  = 1'b0;
      cyc();
      if (acc) issued++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stall_issued", 69'(issued), 69'(6));
    chk("stall_drained", 69'(sbq.size()), 69'(0));
    chk("stall_cycles", 69'(stall_cycles), 69'(3));

    // Reset with three operand sets in flight.
    for (int j = 0; j < 3; j++) begin
      a_in     = 64'(10 + j);
      b_in     = 64'(20 + j);
      in_valid = 1'b1;
      cyc();
      chk("rst_pre_accept", 69'(acc), 69'(1));
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("rst_mid_clear", obs_all, 69'(0));
    end
    send(64'd1, 64'd2, 1'b0);
    latency_check("latency_after_reset");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
